memory_cycle: RTL and testbench
===============================

# memory_cycle

Memory-access stage of the five-stage RV32 pipeline. It consumes the EX/MEM pipeline register outputs (RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM) and drives a request/ready data-memory bus. While an access is pending it raises a stall to the upstream stages. It produces the MEM/WB register outputs consumed by writeback.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255 — wait-state cycles in WAIT before a forced abort; legal range 1..255.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- RegWriteM  in  1  register-file write enable of the instruction in MEM.
- MemWriteM  in  1  store request.
- ResultSrcM  in  1  1 = load; result comes from memory.
- RD_M  in  5  destination register.
- PCPlus4M  in  32  PC+4 of the instruction.
- WriteDataM  in  32  store data.
- ALU_ResultM  in  32  effective address / ALU result.
- mem_req  out  1  bus request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  out  32  word address {ALU_ResultM[31:2],2'b00}.
- mem_wdata  out  32  equals WriteDataM.
- mem_ready  in  1  bus completion, sampled on clk.
- mem_rdata  in  32  read data, valid when mem_ready=1.
- stall_M  out  1  holds the PC, IF/ID, ID/EX and EX/MEM registers.
- bus_err  out  1  sticky error flag; cleared only by reset.
- RegWriteW  out  1  MEM/WB register outputs.
- ResultSrcW  out  1
- RD_W  out  5
- PCPlus4W  out  32
- ALU_ResultW  out  32
- ReadDataW  out  32  load data; 0 for non-loads.

## Operation
- access = MemWriteM | ResultSrcM. A store takes priority if both are set (mem_we=1).
- misaligned = access & (ALU_ResultM[1:0] != 0). A misaligned access issues no bus request, sets bus_err, completes immediately with ReadDataW=0 and no stall, and still writes back.
- State machine, two states: IDLE and WAIT. An 8-bit wait counter wcnt runs alongside it.
- IDLE:
  - mem_req = access & ~misaligned (combinational).
  - If mem_req=1 and mem_ready=1, the access completes (zero-wait). Stay in IDLE.
  - If mem_req=1 and mem_ready=0, go to WAIT with wcnt=1.
- WAIT:
  - mem_req=1. Upstream holds the EX/MEM inputs stable because of stall_M.
  - If mem_ready=1, the access completes. Go to IDLE, wcnt=0.
  - Else if wcnt==TIMEOUT_CYCLES, abort: completes with read data 0, bus_err<=1. Go to IDLE.
  - Else wcnt<=wcnt+1.
- complete = access & (misaligned | (mem_req & mem_ready) | abort).
- stall_M = access & ~complete (combinational).
- MEM/WB register updates on every clk edge:
  - If stall_M=0: RegWriteW, ResultSrcW, RD_W, PCPlus4W and ALU_ResultW load from the M inputs. ReadDataW loads mem_rdata for a completed load, 0 for an abort, misaligned access or non-load.
  - If stall_M=1: insert a bubble. RegWriteW<=0 and ResultSrcW<=0; the other W fields hold.
- mem_ready while mem_req=0 is ignored.
- With rst=0: mem_req=0 and stall_M=0, forced combinationally.

## Timing
- Reset values: every registered output is 0, state=IDLE, wcnt=0, bus_err=0.
- Reset asserted mid-access: the access is abandoned, mem_req drops immediately, and no writeback occurs.
- Non-memory instruction: one cycle through MEM; W outputs are valid after the next edge.
- Zero-wait access: stall_M stays 0. ReadDataW is valid one cycle after mem_req.
- N wait cycles (mem_ready first high in the (N+1)th request cycle):
  - stall_M is high for N cycles.
  - N bubbles enter MEM/WB.
  - The real result appears on the edge that samples mem_ready.
- Abort: stall_M is high for TIMEOUT_CYCLES cycles. Completion and bus_err=1 take effect on the following edge.
- After completion from WAIT, the next instruction is presented on the next cycle. It may request in IDLE with no dead cycle.

## Test plan
- Reset: with rst=0, all outputs are 0 and mem_req=0. After release, the first ALU instruction (RD_M=5, ALU_ResultM=0x1234) gives RD_W=5, ALU_ResultW=0x1234, RegWriteW=1 one cycle later.
- Zero-wait load: ALU_ResultM=0x100 with mem_ready held 1 and mem_rdata=0xDEADBEEF gives mem_addr=0x100, stall_M=0, and next cycle ReadDataW=0xDEADBEEF, ResultSrcW=1.
- Store with 3 wait states: ALU_ResultM=0x200, WriteDataM=0xA5A5A5A5, mem_ready high on the 4th request cycle. Required: stall_M high 3 cycles, RegWriteW=0 during the bubbles, mem_we=1 and mem_wdata stable throughout, then stall_M drops.
- Timeout: TIMEOUT_CYCLES=4, load with mem_ready never asserted. Required: stall_M high 4 cycles, then ReadDataW=0, bus_err=1 and mem_req=0 after completion.
- Misaligned: load at ALU_ResultM=0x102 gives mem_req=0, stall_M=0, bus_err=1 and ReadDataW=0.
- Reset mid-WAIT: pull rst low in the 2nd wait cycle. Required: mem_req and stall_M go to 0 immediately, W outputs are 0, and bus_err=0.

Source files
------------

// File: rtl/memory_cycle.sv
// memory_cycle: MEM stage of the RV32 pipeline.
// Turns the EX/MEM register outputs into a request/ready data-memory access.
// Raises stall_M while an access is outstanding and feeds the MEM/WB register.
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   RegWriteM..ALU_ResultM   EX/MEM register outputs
//   mem_req/we/addr/wdata    bus request (combinational)
//   mem_ready, mem_rdata     bus completion and read data
//   stall_M                  upstream hold (combinational)
//   bus_err                  sticky misalign/timeout flag
//   RegWriteW..ReadDataW     MEM/WB register outputs
module memory_cycle #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        ResultSrcM,
  input  logic [4:0]  RD_M,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] ALU_ResultM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        stall_M,
  output logic        bus_err,
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [4:0]  RD_W,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned DATA_W = 32;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   wcnt_q, wcnt_d;
  logic               access_c, misaligned_c, load_c;
  logic               req_c, abort_c, complete_c, stall_c;

  // Instruction classification; a store wins when both flags are set.
  assign access_c     = MemWriteM | ResultSrcM;
  assign misaligned_c = access_c & (ALU_ResultM[1:0] != 2'b00);
  assign load_c       = ResultSrcM & ~MemWriteM;

  // State register and wait counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Next-state, request and timeout decode.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    req_c   = 1'b0;
    abort_c = 1'b0;
    case (state_q)
      IDLE: begin
        req_c = access_c & ~misaligned_c;
        if (req_c && !mem_ready) begin
          state_d = WAIT;
          wcnt_d  = CNT_W'(1);
        end
      end
      WAIT: begin
        req_c = 1'b1;
        if (mem_ready) begin
          state_d = IDLE;
          wcnt_d  = '0;
        end else if (wcnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          abort_c = 1'b1;
          state_d = IDLE;
          wcnt_d  = '0;
        end else begin
          wcnt_d = wcnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  assign complete_c = access_c & (misaligned_c | (req_c & mem_ready) | abort_c);
  assign stall_c    = access_c & ~complete_c;

  // Bus-side and stall outputs are combinational and forced low in reset.
  assign mem_req   = rst & req_c;
  assign stall_M   = rst & stall_c;
  assign mem_we    = MemWriteM;
  assign mem_addr  = {ALU_ResultM[31:2], 2'b00};
  assign mem_wdata = WriteDataM;

  // MEM/WB register: bubble while stalled, otherwise capture the instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteW   <= 1'b0;
      ResultSrcW  <= 1'b0;
      RD_W        <= '0;
      PCPlus4W    <= '0;
      ALU_ResultW <= '0;
      ReadDataW   <= '0;
    end else if (stall_c) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 1'b0;
    end else begin
      RegWriteW   <= RegWriteM;
      ResultSrcW  <= ResultSrcM;
      RD_W        <= RD_M;
      PCPlus4W    <= PCPlus4M;
      ALU_ResultW <= ALU_ResultM;
      ReadDataW   <= (load_c & req_c & mem_ready) ? mem_rdata : DATA_W'(0);
    end
  end

  // Sticky error: misaligned access or wait-state timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_err <= 1'b0;
    end else if (misaligned_c || abort_c) begin
      bus_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_memory_cycle.sv
// Testbench for memory_cycle: directed cases plus a random instruction stream,
// expected MEM/WB results queued by the driver and checked by a monitor.
module tb_memory_cycle;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        RegWriteM = 1'b0, MemWriteM = 1'b0, ResultSrcM = 1'b0;
  logic [4:0]  RD_M = '0;
  logic [31:0] PCPlus4M = '0, WriteDataM = '0, ALU_ResultM = '0;
  logic        mem_req, mem_we, mem_ready = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic        stall_M, bus_err;
  logic        RegWriteW, ResultSrcW;
  logic [4:0]  RD_W;
  logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;

  memory_cycle #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .stall_M(stall_M), .bus_err(bus_err),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
    .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic        rs;
    logic [4:0]  rd;
    logic [31:0] pc4;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  logic exp_err = 1'b0;
  bit   mon_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a non-stalled cycle retires one instruction into MEM/WB,
  // a stalled cycle must leave a bubble.
  initial begin : monitor
    logic s, r;
    exp_t e;
    forever begin
      @(negedge clk);
      s = stall_M;
      r = rst;
      @(posedge clk);
      #1;
      if (mon_en && r) begin
        if (s) begin
          chk("bubble_regwrite", 32'(RegWriteW), 32'd0);
          chk("bubble_resultsrc", 32'(ResultSrcW), 32'd0);
        end else if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL wb_unexpected: got retire with empty queue want none (t=%0t)", $time);
        end else begin
          e = sb_q.pop_front();
          chk("RegWriteW", 32'(RegWriteW), 32'(e.rw));
          chk("ResultSrcW", 32'(ResultSrcW), 32'(e.rs));
          chk("RD_W", 32'(RD_W), 32'(e.rd));
          chk("PCPlus4W", PCPlus4W, e.pc4);
          chk("ALU_ResultW", ALU_ResultW, e.alu);
          chk("ReadDataW", ReadDataW, e.rdata);
          chk("bus_err", 32'(bus_err), 32'(e.err));
        end
      end
    end
  end

  // Present one instruction; the bus answers after n wait cycles (n > T never answers).
  task automatic run_instr(input logic we, input logic ld, input logic rwr,
                           input logic [4:0] rd, input logic [31:0] pc4,
                           input logic [31:0] alu, input logic [31:0] wd,
                           input int n, input logic [31:0] rdat);
    logic acc, mis, is_ld, abort;
    int   exp_st, k;
    exp_t e;
    acc    = we | ld;
    mis    = acc && (alu[1:0] != 2'b00);
    is_ld  = ld && !we;
    abort  = acc && !mis && (n > T);
    exp_st = (!acc || mis) ? 0 : (abort ? T : n);
    exp_err = exp_err | mis | abort;
    e.rw = rwr; e.rs = ld; e.rd = rd; e.pc4 = pc4; e.alu = alu;
    e.rdata = (acc && !mis && !abort && is_ld) ? rdat : 32'd0;
    e.err = exp_err;
    sb_q.push_back(e);
    RegWriteM = rwr; MemWriteM = we; ResultSrcM = ld; RD_M = rd;
    PCPlus4M = pc4; ALU_ResultM = alu; WriteDataM = wd;
    k = 0;
    forever begin
      if (acc && !mis) begin
        mem_ready = (k == n);
        mem_rdata = (k == n) ? rdat : $urandom;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
      @(negedge clk);
      chk("mem_req", 32'(mem_req), 32'(acc && !mis));
      if (acc && !mis) begin
        chk("mem_addr", mem_addr, {alu[31:2], 2'b00});
        chk("mem_we", 32'(mem_we), 32'(we));
        chk("mem_wdata", mem_wdata, wd);
      end
      if (!stall_M) break;
      k++;
      if (k > T + 2) begin
        $display("FAIL stall_bound: got stall beyond %0d cycles want release", T + 2);
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("stall_cycles", 32'(k), 32'(exp_st));
    @(posedge clk);
    #1;
  endtask

  task automatic run_random();
    logic [1:0]  op;
    logic [31:0] alu;
    op  = 2'($urandom_range(0, 3));
    alu = $urandom;
    if ($urandom_range(0, 7) != 0) alu[1:0] = 2'b00;
    run_instr(op[1], op[0], 1'($urandom_range(0, 1)), 5'($urandom), $urandom, alu,
              $urandom, $urandom_range(0, 6), $urandom);
  endtask

  initial begin : driver
    // In reset: a would-be request must be suppressed and all outputs zero.
    MemWriteM = 1'b1; ALU_ResultM = 32'h40; RegWriteM = 1'b1; mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_stall", 32'(stall_M), 32'd0);
    chk("rst_regwrite", 32'(RegWriteW), 32'd0);
    chk("rst_resultsrc", 32'(ResultSrcW), 32'd0);
    chk("rst_rd", 32'(RD_W), 32'd0);
    chk("rst_pc4", PCPlus4W, 32'd0);
    chk("rst_alu", ALU_ResultW, 32'd0);
    chk("rst_rdata", ReadDataW, 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    mon_en = 1'b1;

    // Directed cases.
    run_instr(1'b0, 1'b0, 1'b1, 5'd5, 32'h4, 32'h1234, 32'h0, 0, 32'h0);
    run_instr(1'b0, 1'b1, 1'b1, 5'd7, 32'h8, 32'h100, 32'h0, 0, 32'hDEADBEEF);
    run_instr(1'b1, 1'b0, 1'b0, 5'd0, 32'hC, 32'h200, 32'hA5A5A5A5, 3, 32'h0);
    run_instr(1'b0, 1'b1, 1'b1, 5'd9, 32'h10, 32'h300, 32'h0, 99, 32'h12345678);
    run_instr(1'b0, 1'b1, 1'b1, 5'd10, 32'h14, 32'h102, 32'h0, 0, 32'h87654321);
    run_instr(1'b0, 1'b1, 1'b1, 5'd11, 32'h18, 32'h104, 32'h0, T, 32'hCAFEF00D);

    for (int i = 0; i < 150; i++) run_random();

    // Reset during the second wait cycle of a load.
    RegWriteM = 1'b1; MemWriteM = 1'b0; ResultSrcM = 1'b1; RD_M = 5'd3;
    PCPlus4M = 32'h50; ALU_ResultM = 32'h400; mem_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("pre_rst_stall", 32'(stall_M), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_mem_req", 32'(mem_req), 32'd0);
    chk("midrst_stall", 32'(stall_M), 32'd0);
    chk("midrst_regwrite", 32'(RegWriteW), 32'd0);
    chk("midrst_resultsrc", 32'(ResultSrcW), 32'd0);
    chk("midrst_rd", 32'(RD_W), 32'd0);
    chk("midrst_pc4", PCPlus4W, 32'd0);
    chk("midrst_alu", ALU_ResultW, 32'd0);
    chk("midrst_rdata", ReadDataW, 32'd0);
    chk("midrst_bus_err", 32'(bus_err), 32'd0);
    sb_q.delete();
    exp_err = 1'b0;
    repeat (2) @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int i = 0; i < 30; i++) run_random();

    @(negedge clk);
    chk("queue_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
